// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - control, memory-read and array-feed signals of systolic_feeder
interface systolic_feeder_if #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic              continuous;
    logic              mem_en;
    logic [ADDR_W-1:0] addr;
    logic [N*W-1:0]    a_rdata;
    logic [N*W-1:0]    b_rdata;
    logic [N*W-1:0]    a_out;
    logic [N*W-1:0]    b_out;
    logic              valid_out;
    logic              arr_clear;
    logic              busy;
    logic              done;
    logic [7:0]        pass_cnt;

    modport master (
        output start, continuous, a_rdata, b_rdata,
        input  mem_en, addr, a_out, b_out, valid_out, arr_clear, busy, done, pass_cnt
    );

    modport slave (
        input  start, continuous, a_rdata, b_rdata,
        output mem_en, addr, a_out, b_out, valid_out, arr_clear, busy, done, pass_cnt
    );
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand sequencer feeding skewed A/B rows into an NxN systolic array
module systolic_feeder #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int MEM_LAT   = 1,
    parameter int DRAIN_CYC = MEM_LAT + 1 + 3 * (N - 1)
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int                DCNT_W     = $clog2(DRAIN_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(DRAIN_CYC - 1);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [7:0]         pass_q, pass_d;
    logic [MEM_LAT-1:0] vld_q;
    logic               fetch;
    logic               rd_v;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dcnt_d  = dcnt_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == LAST_DRAIN) begin
                    dcnt_d  = '0;
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                pass_d  = pass_q + 8'd1;
                state_d = bus.continuous ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dcnt_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dcnt_q  <= dcnt_d;
            pass_q  <= pass_d;
        end
    end

    assign fetch        = (state_q == S_FETCH);
    assign bus.mem_en   = fetch;
    assign bus.addr     = addr_q;
    assign bus.arr_clear = (state_q == S_CLEAR);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.pass_cnt = pass_q;

    // Tracks which cycles the memory outputs carry a row requested during FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= fetch;
            for (int j = 1; j < MEM_LAT; j++) begin
                vld_q[j] <= vld_q[j-1];
            end
        end
    end

    assign rd_v = vld_q[MEM_LAT-1];

    // Stage 0 is the shared input register; lane gi adds gi more stages, with its own valid.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [W-1:0] a_pipe_q [0:gi];
        logic [W-1:0] b_pipe_q [0:gi];
        logic         v_pipe_q [0:gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= gi; j++) begin
                    a_pipe_q[j] <= '0;
                    b_pipe_q[j] <= '0;
                    v_pipe_q[j] <= 1'b0;
                end
            end else begin
                a_pipe_q[0] <= rd_v ? bus.a_rdata[gi*W +: W] : '0;
                b_pipe_q[0] <= rd_v ? bus.b_rdata[gi*W +: W] : '0;
                v_pipe_q[0] <= rd_v;
                for (int j = 1; j <= gi; j++) begin
                    a_pipe_q[j] <= a_pipe_q[j-1];
                    b_pipe_q[j] <= b_pipe_q[j-1];
                    v_pipe_q[j] <= v_pipe_q[j-1];
                end
            end
        end

        assign bus.a_out[gi*W +: W] = v_pipe_q[gi] ? a_pipe_q[gi] : '0;
        assign bus.b_out[gi*W +: W] = v_pipe_q[gi] ? b_pipe_q[gi] : '0;

        if (gi == 0) begin : g_valid
            assign bus.valid_out = v_pipe_q[0];
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;
    localparam int N        = 4;
    localparam int W        = 8;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int DONE_OFS = 20;
    localparam logic [N*W-1:0] GARB = {N{8'hEE}};

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .W(W), .ADDR_W(ADDR_W)) bus ();
    systolic_feeder_if #(.N(N), .W(W), .ADDR_W(ADDR_W)) bus2 ();

    systolic_feeder #(.N(N), .W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MEM_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    systolic_feeder #(.N(N), .W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MEM_LAT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    function automatic logic [N*W-1:0] mem_row(input int k, input bit is_b);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(16 * k + i + (is_b ? 128 : 0));
        return r;
    endfunction

    // Row k lane i expected on the array side in cycle f+k+lat+1+i, zero elsewhere.
    function automatic logic [N*W-1:0] exp_out(input int c, input int f, input int lat, input bit is_b);
        logic [N*W-1:0] r;
        int k;
        r = '0;
        for (int i = 0; i < N; i++) begin
            k = c - f - lat - 1 - i;
            if (k >= 0 && k < DEPTH) r[i*W +: W] = W'(16 * k + i + (is_b ? 128 : 0));
        end
        return r;
    endfunction

    logic [N*W-1:0] a2_d1, b2_d1;

    always @(posedge clk) begin
        bus.a_rdata  <= bus.mem_en ? mem_row(int'(bus.addr), 1'b0) : GARB;
        bus.b_rdata  <= bus.mem_en ? mem_row(int'(bus.addr), 1'b1) : GARB;
        a2_d1        <= bus2.mem_en ? mem_row(int'(bus2.addr), 1'b0) : GARB;
        b2_d1        <= bus2.mem_en ? mem_row(int'(bus2.addr), 1'b1) : GARB;
        bus2.a_rdata <= a2_d1;
        bus2.b_rdata <= b2_d1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Expected behaviour of the MEM_LAT=1 instance for back-to-back passes starting CLEAR at cl0.
    task automatic check_ctl(input string sc, input int c, input int npass, input int cl0, input int pc0);
        logic ec, ef, ev, eb, ed;
        int   ea, epc, cl, f;
        logic [N*W-1:0] eao, ebo;
        ec = 0; ef = 0; ev = 0; eb = 0; ed = 0; ea = 0; epc = pc0; eao = '0; ebo = '0;
        for (int p = 0; p < npass; p++) begin
            cl = cl0 + 21 * p;
            f  = cl + 1;
            ec |= (c == cl);
            if (c >= f && c < f + DEPTH) begin
                ef = 1;
                ea = c - f;
            end
            ev |= (c >= f + 2 && c <= f + DEPTH + 1);
            eb |= (c >= cl && c <= cl + DONE_OFS);
            ed |= (c == cl + DONE_OFS);
            if (c > cl + DONE_OFS) epc++;
            eao |= exp_out(c, f, 1, 1'b0);
            ebo |= exp_out(c, f, 1, 1'b1);
        end
        check_eq($sformatf("%s c%0d arr_clear", sc, c), 32'(bus.arr_clear), 32'(ec));
        check_eq($sformatf("%s c%0d mem_en", sc, c), 32'(bus.mem_en), 32'(ef));
        if (ef) check_eq($sformatf("%s c%0d addr", sc, c), 32'(bus.addr), 32'(ea));
        check_eq($sformatf("%s c%0d valid_out", sc, c), 32'(bus.valid_out), 32'(ev));
        check_eq($sformatf("%s c%0d busy", sc, c), 32'(bus.busy), 32'(eb));
        check_eq($sformatf("%s c%0d done", sc, c), 32'(bus.done), 32'(ed));
        check_eq($sformatf("%s c%0d pass_cnt", sc, c), 32'(bus.pass_cnt), 32'(epc));
        check_eq($sformatf("%s c%0d a_out", sc, c), bus.a_out, eao);
        check_eq($sformatf("%s c%0d b_out", sc, c), bus.b_out, ebo);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;  bus.continuous = 1'b0;
        bus2.start = 1'b0; bus2.continuous = 1'b0;

        // reset held 3 cycles, then idle
        do_reset(3);
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("idle c%0d ctl", c),
                     {27'd0, bus.mem_en, bus.arr_clear, bus.busy, bus.done, bus.valid_out}, 32'd0);
            check_eq($sformatf("idle c%0d addr", c), 32'(bus.addr), 32'd0);
            check_eq($sformatf("idle c%0d pass_cnt", c), 32'(bus.pass_cnt), 32'd0);
            check_eq($sformatf("idle c%0d a_out", c), bus.a_out, 32'd0);
            check_eq($sformatf("idle c%0d b_out", c), bus.b_out, 32'd0);
            @(negedge clk);
        end

        // single pass with hand-picked lane values
        do_reset(1);
        for (int c = 0; c <= 24; c++) begin
            bus.start = (c == 0);
            check_ctl("single", c, 1, 1, 0);
            if (c == 4)  check_eq("single a lane0 c4", 32'(bus.a_out[7:0]), 32'h00);
            if (c == 4)  check_eq("single b lane0 c4", 32'(bus.b_out[7:0]), 32'h80);
            if (c == 7)  check_eq("single a lane3 c7", 32'(bus.a_out[31:24]), 32'h03);
            if (c == 14) check_eq("single a lane3 c14", 32'(bus.a_out[31:24]), 32'h73);
            @(negedge clk);
        end

        // continuous mode: two passes back to back, dropped before the second DONE
        do_reset(1);
        for (int c = 0; c <= 45; c++) begin
            bus.start      = (c == 0);
            bus.continuous = (c < 30);
            check_ctl("cont", c, 2, 1, 0);
            @(negedge clk);
        end
        bus.continuous = 1'b0;

        // start pulses while busy are ignored
        do_reset(1);
        for (int c = 0; c <= 24; c++) begin
            bus.start = (c == 0 || c == 5 || c == 15);
            check_ctl("busy_start", c, 1, 1, 0);
            @(negedge clk);
        end

        // reset mid-FETCH (pass_cnt starts at 1 from the previous pass), then a fresh pass
        for (int c = 0; c <= 32; c++) begin
            bus.start = (c == 0 || c == 8);
            reset     = (c == 6);
            if (c <= 6) check_ctl("midrst", c, 1, 1, 1);
            else        check_ctl("midrst", c, 1, 9, 0);
            @(negedge clk);
        end

        // MEM_LAT=2 instance
        do_reset(1);
        for (int c = 0; c <= 24; c++) begin
            bus2.start = (c == 0);
            check_eq($sformatf("lat2 c%0d valid_out", c), 32'(bus2.valid_out), 32'(c >= 5 && c <= 12));
            check_eq($sformatf("lat2 c%0d done", c), 32'(bus2.done), 32'(c == 22));
            check_eq($sformatf("lat2 c%0d pass_cnt", c), 32'(bus2.pass_cnt), 32'(c >= 23));
            check_eq($sformatf("lat2 c%0d a_out", c), bus2.a_out, exp_out(c, 2, 2, 1'b0));
            check_eq($sformatf("lat2 c%0d b_out", c), bus2.b_out, exp_out(c, 2, 2, 1'b1));
            if (c == 5)  check_eq("lat2 b lane0 c5", 32'(bus2.b_out[7:0]), 32'h80);
            if (c == 15) check_eq("lat2 a lane3 c15", 32'(bus2.a_out[31:24]), 32'h73);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
